// File: rtl/crc_mem_ctrl.sv
// rtl/crc_mem_ctrl.sv - command sequencer for the CRC-protected 8x4 RAM; optional error counter under CRC_ERR_CNT_EN
module crc_mem_ctrl #(
  parameter logic [3:0] POLY       = 4'b1001,
  parameter int         RAM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_addr,
  input  logic [3:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_rdata,
  output logic [2:0] rsp_crc,
  output logic       rsp_crc_err,
  output logic [2:0] ram_address,
  output logic [3:0] ram_data_in,
  output logic       ram_write_en,
  output logic       ram_read_en,
  input  logic [3:0] ram_data_out,
  output logic [3:0] err_cnt
);

  typedef enum logic [3:0] {
    IDLE,
    W_CALC,
    W_DATA,
    W_CRC,
    R_DATA,
    R_DWAIT,
    R_CRC,
    R_CWAIT,
    R_CALC,
    RSP
  } state_t;

  // Wait counter value on the cycle where the RAM output is valid.
  localparam logic [1:0] LAST_WAIT = 2'(RAM_RD_LAT - 1);
  // Bit counter value on the fourth (last) CRC step.
  localparam logic [1:0] LAST_BIT  = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic [3:0] stored_q, stored_d;
  logic [2:0] crc_q, crc_d;
  logic [3:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0] rsp_crc_q, rsp_crc_d;
  logic       rsp_crc_err_q, rsp_crc_err_d;
  logic [2:0] crc_next;

  // One bit-serial CRC step; POLY[3] is the implied leading term.
  function automatic logic [2:0] crc_step(input logic [2:0] crc, input logic d);
    logic fb;
    fb = crc[2] ^ d;
    return {crc[1:0], 1'b0} ^ (fb ? POLY[2:0] : 3'b000);
  endfunction

  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_crc     = rsp_crc_q;
  assign rsp_crc_err = rsp_crc_err_q;

  // Next-state, datapath updates and RAM/handshake outputs decoded from the current state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    stored_d      = stored_q;
    crc_d         = crc_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_crc_d     = rsp_crc_q;
    rsp_crc_err_d = rsp_crc_err_q;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    ram_address   = 3'b000;
    ram_data_in   = 4'h0;
    ram_write_en  = 1'b0;
    ram_read_en   = 1'b0;
    // Data is consumed MSB first: bit index 3 on the first step, 0 on the last.
    crc_next      = crc_step(crc_q, data_q[LAST_BIT - cnt_q]);

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          data_d  = cmd_wdata;
          crc_d   = 3'b000;
          cnt_d   = 2'd0;
          state_d = cmd_write ? W_CALC : R_DATA;
        end
      end
      W_CALC: begin
        crc_d = crc_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_BIT) begin
          state_d = W_DATA;
        end
      end
      W_DATA: begin
        ram_address  = {1'b0, addr_q};
        ram_data_in  = data_q;
        ram_write_en = 1'b1;
        state_d      = W_CRC;
      end
      W_CRC: begin
        ram_address   = {1'b1, addr_q};
        ram_data_in   = {1'b0, crc_q};
        ram_write_en  = 1'b1;
        rsp_crc_d     = crc_q;
        rsp_crc_err_d = 1'b0;
        state_d       = RSP;
      end
      R_DATA: begin
        ram_address = {1'b0, addr_q};
        ram_read_en = 1'b1;
        cnt_d       = 2'd0;
        state_d     = R_DWAIT;
      end
      R_DWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_WAIT) begin
          data_d  = ram_data_out;
          cnt_d   = 2'd0;
          state_d = R_CRC;
        end
      end
      R_CRC: begin
        ram_address = {1'b1, addr_q};
        ram_read_en = 1'b1;
        cnt_d       = 2'd0;
        state_d     = R_CWAIT;
      end
      R_CWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_WAIT) begin
          stored_d = ram_data_out;
          cnt_d    = 2'd0;
          crc_d    = 3'b000;
          state_d  = R_CALC;
        end
      end
      R_CALC: begin
        crc_d = crc_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_BIT) begin
          rsp_rdata_d   = data_q;
          rsp_crc_d     = crc_next;
          // A set bit 3 in the stored word can never come from a genuine CRC write.
          rsp_crc_err_d = (stored_q[2:0] != crc_next) | stored_q[3];
          state_d       = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      addr_q        <= 2'd0;
      data_q        <= 4'h0;
      stored_q      <= 4'h0;
      crc_q         <= 3'b000;
      rsp_rdata_q   <= 4'h0;
      rsp_crc_q     <= 3'b000;
      rsp_crc_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      stored_q      <= stored_d;
      crc_q         <= crc_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_crc_q     <= rsp_crc_d;
      rsp_crc_err_q <= rsp_crc_err_d;
    end
  end

`ifdef CRC_ERR_CNT_EN
  logic [3:0] err_cnt_q, err_cnt_d;

  // Count responses flagging a CRC error, saturating at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == RSP && rsp_crc_err_q && err_cnt_q != 4'hF) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= 4'h0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 4'h0;
`endif

endmodule

// File: tb/tb_crc_mem_ctrl.sv
// tb/tb_crc_mem_ctrl.sv - scoreboard testbench for crc_mem_ctrl with a behavioural ram_8x4
module tb_crc_mem_ctrl;

  localparam int RAM_RD_LAT = 1;
  localparam int WR_LAT     = 7;
  localparam int RD_LAT     = 7 + 2 * RAM_RD_LAT;
`ifdef CRC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_addr;
  logic [3:0] cmd_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic [2:0] rsp_crc;
  logic       rsp_crc_err;
  logic [2:0] ram_address;
  logic [3:0] ram_data_in;
  logic       ram_write_en, ram_read_en;
  logic [3:0] ram_data_out;
  logic [3:0] err_cnt;

  always #5 clk = ~clk;

  crc_mem_ctrl #(.POLY(4'b1001), .RAM_RD_LAT(RAM_RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_crc(rsp_crc), .rsp_crc_err(rsp_crc_err),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ram_data_out(ram_data_out), .err_cnt(err_cnt)
  );

  // Behavioural RAM: synchronous write, registered read with RAM_RD_LAT stages, backdoor port.
  logic [3:0] ram_mem [8] = '{default: 4'h0};
  logic [3:0] rd_pipe [3] = '{default: 4'h0};
  logic       bd_we = 1'b0;
  logic [2:0] bd_addr = 3'd0;
  logic [3:0] bd_data = 4'h0;

  always @(posedge clk) begin
    if (bd_we) ram_mem[bd_addr] <= bd_data;
    else if (ram_write_en) ram_mem[ram_address] <= ram_data_in;
    if (ram_read_en) rd_pipe[0] <= ram_mem[ram_address];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign ram_data_out = rd_pipe[RAM_RD_LAT-1];

  typedef struct {
    logic [3:0] rdata;
    logic [2:0] crc;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         rsp_count = 0;
  logic [3:0] exp_mem [8];
  logic [3:0] last_rdata = 4'h0;
  logic [3:0] exp_err_cnt = 4'h0;
  logic       prev_rsp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference CRC as polynomial long division of data*x^3 by x^3+1.
  function automatic logic [2:0] crc_model(input logic [3:0] d);
    logic [6:0] v;
    logic [6:0] g;
    v = {d, 3'b000};
    g = 7'b1001000;
    for (int i = 6; i >= 3; i--) begin
      if (v[i]) v = v ^ (g >> (6 - i));
    end
    return v[2:0];
  endfunction

  function automatic exp_t build_exp(input logic wr, input logic [1:0] a, input logic [3:0] d);
    exp_t e;
    logic [2:0] c;
    if (wr) begin
      c = crc_model(d);
      e.rdata = last_rdata;
      e.crc = c;
      e.err = 1'b0;
      e.lat = WR_LAT;
      exp_mem[{1'b0, a}] = d;
      exp_mem[{1'b1, a}] = {1'b0, c};
    end else begin
      c = crc_model(exp_mem[{1'b0, a}]);
      e.rdata = exp_mem[{1'b0, a}];
      e.crc = c;
      e.err = (exp_mem[{1'b1, a}][2:0] != c) | exp_mem[{1'b1, a}][3];
      e.lat = RD_LAT;
      last_rdata = e.rdata;
    end
    e.acc = 0;
    return e;
  endfunction

  // Response monitor: pops the scoreboard on every rsp_valid and checks the RAM enables.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (ram_write_en && ram_read_en) begin
        tests_run++; tests_failed++;
        $display("FAIL ram_we_re_excl: both enables high at cycle %0d", cyc);
      end
      if (rsp_valid) begin
        rsp_count++;
        tests_run++;
        if (prev_rsp) begin
          tests_failed++;
          $display("FAIL rsp_pulse_width: rsp_valid high on consecutive cycles, expected 1 cycle");
        end
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
        end else begin
          e = sb.pop_front();
          tests_run += 4;
          if (rsp_rdata !== e.rdata) begin
            tests_failed++;
            $display("FAIL rsp_rdata: got %h, expected %h", rsp_rdata, e.rdata);
          end
          if (rsp_crc !== e.crc) begin
            tests_failed++;
            $display("FAIL rsp_crc: got %b, expected %b", rsp_crc, e.crc);
          end
          if (rsp_crc_err !== e.err) begin
            tests_failed++;
            $display("FAIL rsp_crc_err: got %b, expected %b", rsp_crc_err, e.err);
          end
          if (cyc - e.acc + 1 != e.lat) begin
            tests_failed++;
            $display("FAIL rsp_latency: got %0d, expected %0d", cyc - e.acc + 1, e.lat);
          end
          if (CNT_EN && e.err && exp_err_cnt != 4'hF) exp_err_cnt = exp_err_cnt + 4'd1;
        end
      end
    end
    prev_rsp = rsp_valid;
  end

  task automatic issue(input logic wr, input logic [1:0] a, input logic [3:0] d, input bit track);
    exp_t e;
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL issue_timeout: got cmd_ready=0, expected 1 within 50 cycles");
      cmd_valid = 1'b0;
      return;
    end
    if (track) begin
      e = build_exp(wr, a, d);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL rsp_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic backdoor(input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    tests_run++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_write_en !== 1'b0 ||
        ram_read_en !== 1'b0 || err_cnt !== 4'h0 || ram_address !== 3'd0) begin
      tests_failed++;
      $display("FAIL %s: got rdy=%b vld=%b we=%b re=%b cnt=%h addr=%0d, expected 1 0 0 0 0 0",
               tag, cmd_ready, rsp_valid, ram_write_en, ram_read_en, err_cnt, ram_address);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_wdata = 4'h0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_values");
    tests_run++;
    if (rsp_rdata !== 4'h0 || rsp_crc !== 3'b000 || rsp_crc_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rsp: got %h %b %b, expected 0 000 0", rsp_rdata, rsp_crc, rsp_crc_err);
    end
    reset = 1'b1;
    issue(1'b1, 2'd2, 4'b0101, 1'b0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_ready: got %b, expected 0", cmd_ready);
    end
    #2 reset = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_unwritten();
    issue(1'b0, 2'd2, 4'h0, 1'b1);
    wait_idle();
  endtask

  task automatic test_write();
    logic [3:0] pat [4];
    pat[0] = 4'b1010; pat[1] = 4'b0001; pat[2] = 4'b1000; pat[3] = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 2'(i), pat[i], 1'b1);
      wait_idle();
      tests_run += 2;
      if (ram_mem[i] !== exp_mem[i]) begin
        tests_failed++;
        $display("FAIL ram_data[%0d]: got %b, expected %b", i, ram_mem[i], exp_mem[i]);
      end
      if (ram_mem[i+4] !== exp_mem[i+4]) begin
        tests_failed++;
        $display("FAIL ram_crc[%0d]: got %b, expected %b", i + 4, ram_mem[i+4], exp_mem[i+4]);
      end
    end
  endtask

  task automatic test_read();
    for (int i = 3; i >= 0; i--) begin
      issue(1'b0, 2'(i), 4'h0, 1'b1);
      wait_idle();
    end
  endtask

  task automatic test_corrupt();
    backdoor(3'd7, 4'b0001);
    issue(1'b0, 2'd3, 4'h0, 1'b1);
    wait_idle();
    tests_run++;
    if (err_cnt !== exp_err_cnt) begin
      tests_failed++;
      $display("FAIL err_cnt_first: got %h, expected %h", err_cnt, exp_err_cnt);
    end
    backdoor(3'd7, 4'b1110);
    issue(1'b0, 2'd3, 4'h0, 1'b1);
    wait_idle();
    tests_run++;
    if (err_cnt !== exp_err_cnt) begin
      tests_failed++;
      $display("FAIL err_cnt_bit3: got %h, expected %h", err_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_err_sat();
    for (int i = 0; i < 14; i++) begin
      issue(1'b0, 2'd3, 4'h0, 1'b1);
      wait_idle();
    end
    tests_run++;
    if (err_cnt !== exp_err_cnt) begin
      tests_failed++;
      $display("FAIL err_cnt_sat: got %h, expected %h", err_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int base;
    bit seen;
    base = rsp_count;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_wdata = 4'b0110;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready_idle: got %b, expected 1", cmd_ready);
    end
    e = build_exp(1'b1, 2'd0, 4'b0110);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_write = 1'b0; cmd_addr = 2'd0; cmd_wdata = 4'b1001;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_ready_busy: got %b, expected 0", cmd_ready);
      end
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL b2b_first_rsp: got no response, expected one");
    end
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready_after_rsp: got %b, expected 1", cmd_ready);
    end
    e = build_exp(1'b0, 2'd0, 4'h0);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    tests_run++;
    if (rsp_count - base != 2) begin
      tests_failed++;
      $display("FAIL b2b_rsp_count: got %0d, expected 2", rsp_count - base);
    end
  endtask

  task automatic test_reset_wcrc();
    bit seen;
    int base;
    backdoor(3'd5, 4'b0100);
    issue(1'b1, 2'd1, 4'b1010, 1'b0);
    exp_mem[1] = 4'b1010;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_write_en && ram_address == 3'd5) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL wcrc_reach: got no W_CRC cycle, expected one");
    end
    base = rsp_count;
    #1 reset = 1'b0;
    #1 check_idle_outputs("wcrc_reset");
    sb.delete();
    exp_err_cnt = 4'h0;
    last_rdata = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    tests_run += 4;
    if (rsp_count != base) begin
      tests_failed++;
      $display("FAIL wcrc_no_rsp: got %0d responses, expected 0", rsp_count - base);
    end
    if (rsp_rdata !== 4'h0) begin
      tests_failed++;
      $display("FAIL wcrc_rdata_reset: got %h, expected 0", rsp_rdata);
    end
    if (ram_mem[1] !== exp_mem[1]) begin
      tests_failed++;
      $display("FAIL wcrc_ram_data: got %b, expected %b", ram_mem[1], exp_mem[1]);
    end
    if (ram_mem[5] !== exp_mem[5]) begin
      tests_failed++;
      $display("FAIL wcrc_ram_crc: got %b, expected %b", ram_mem[5], exp_mem[5]);
    end
    issue(1'b0, 2'd1, 4'h0, 1'b1);
    wait_idle();
    tests_run++;
    if (err_cnt !== exp_err_cnt) begin
      tests_failed++;
      $display("FAIL wcrc_err_cnt: got %h, expected %h", err_cnt, exp_err_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_mem[i] = 4'h0;
    test_reset();
    test_unwritten();
    test_write();
    test_read();
    test_corrupt();
    test_err_sat();
    test_back_to_back();
    test_reset_wcrc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
